// File: rtl/sequencer_pkg.sv
// rtl/sequencer_pkg.sv - shared encodings and instruction routing for stage_sequencer
package sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6
    } state_t;

    localparam logic [1:0] OP_R = 2'b00;
    localparam logic [1:0] OP_J = 2'b01;
    localparam logic [1:0] OP_I = 2'b10;
    localparam logic [1:0] OP_S = 2'b11;

    localparam logic [4:0] FUNC_ANDI   = 5'd0;
    localparam logic [4:0] FUNC_ADDI   = 5'd1;
    localparam logic [4:0] FUNC_LW     = 5'd2;
    localparam logic [4:0] FUNC_SW     = 5'd3;
    localparam logic [4:0] FUNC_BEQ    = 5'd4;
    localparam logic [4:0] FUNC_J      = 5'd0;
    localparam logic [4:0] FUNC_JAL    = 5'd1;
    localparam logic [4:0] FUNC_RS_MAX = 5'd3;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    typedef enum logic [2:0] {
        RT_WB      = 3'd0,
        RT_MEM     = 3'd1,
        RT_BEQ     = 3'd2,
        RT_JMP     = 3'd3,
        RT_ILLEGAL = 3'd4
    } route_t;

    // Where an instruction goes after EXECUTE; anything undefined retires as a faulting NOP.
    function automatic route_t route_of(input logic [1:0] op, input logic [4:0] func);
        route_t r;
        r = RT_ILLEGAL;
        case (op)
            OP_R, OP_S: if (func <= FUNC_RS_MAX) r = RT_WB;
            OP_I: begin
                if (func == FUNC_ANDI || func == FUNC_ADDI)   r = RT_WB;
                else if (func == FUNC_LW || func == FUNC_SW)  r = RT_MEM;
                else if (func == FUNC_BEQ)                    r = RT_BEQ;
            end
            OP_J: if (func == FUNC_J || func == FUNC_JAL) r = RT_JMP;
            default: r = RT_ILLEGAL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - ready-wait counter with timeout compare, shared by FETCH and MEM
module wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    input  logic i_ready,
    input  logic i_clear,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_active && !i_ready) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires on the waiting cycle that would bring the count up to TIMEOUT; ready wins a tie.
    assign o_expired = (TIMEOUT != 0) && i_active && !i_ready && (r_count == LIMIT);

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle stage control FSM; RETIRE_COUNT_EN adds the retired counter
module stage_sequencer
    import sequencer_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  func,
    input  logic        stop,
    input  logic        alu_zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        FetchEnable,
    output logic        DecodeEnable,
    output logic        ExecuteEnable,
    output logic        MemEnable,
    output logic        WriteBackEnable,
    output logic        mem_read,
    output logic        mem_write,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    state_t r_state;
    state_t w_next;
    route_t w_route;
    logic   w_final;
    logic   w_wait_active;
    logic   w_wait_ready;
    logic   w_expired;

    assign w_route       = route_of(op, func);
    assign w_wait_active = (r_state == FETCH) || (r_state == MEM);
    assign w_wait_ready  = (r_state == FETCH) ? imem_ready : dmem_ready;

    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_active  (w_wait_active),
        .i_ready   (w_wait_ready),
        .i_clear   (w_next != r_state),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next    = r_state;
        w_final   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pc_sel    = PC_INC;
        pc_write  = 1'b0;
        case (r_state)
            IDLE:    if (start) w_next = FETCH;
            FETCH: begin
                if (imem_ready)     w_next = DECODE;
                else if (w_expired) w_next = HALT;
            end
            DECODE:  w_next = EXECUTE;
            EXECUTE: begin
                case (w_route)
                    RT_WB:  w_next = WRITEBACK;
                    RT_MEM: w_next = MEM;
                    RT_BEQ: begin
                        w_final = 1'b1;
                        pc_sel  = alu_zero ? PC_BR : PC_INC;
                    end
                    RT_JMP: begin
                        w_final = 1'b1;
                        pc_sel  = PC_JMP;
                    end
                    default: w_final = 1'b1;
                endcase
            end
            MEM: begin
                mem_read  = (func == FUNC_LW);
                mem_write = (func == FUNC_SW);
                if (dmem_ready) begin
                    if (func == FUNC_LW) w_next  = WRITEBACK;
                    else                 w_final = 1'b1;
                end else if (w_expired) begin
                    w_next = HALT;
                end
            end
            WRITEBACK: w_final = 1'b1;
            default:   w_next  = HALT;
        endcase
        if (w_final) begin
            pc_write = 1'b1;
            w_next   = stop ? HALT : FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            FetchEnable     <= 1'b0;
            DecodeEnable    <= 1'b0;
            ExecuteEnable   <= 1'b0;
            MemEnable       <= 1'b0;
            WriteBackEnable <= 1'b0;
            halted          <= 1'b0;
            fault           <= 1'b0;
        end else begin
            r_state         <= w_next;
            FetchEnable     <= (w_next == FETCH);
            DecodeEnable    <= (w_next == DECODE);
            ExecuteEnable   <= (w_next == EXECUTE);
            MemEnable       <= (w_next == MEM);
            WriteBackEnable <= (w_next == WRITEBACK);
            halted          <= (w_next == HALT);
            if (w_expired || (r_state == EXECUTE && w_route == RT_ILLEGAL)) begin
                fault <= 1'b1;
            end
        end
    end

`ifdef RETIRE_COUNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (pc_write) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - randomized self-checking bench for stage_sequencer
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [4:0]  func = '0;
    logic        stop = 1'b0;
    logic        alu_zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        FetchEnable, DecodeEnable, ExecuteEnable, MemEnable, WriteBackEnable;
    logic        mem_read, mem_write, pc_write, halted, fault;
    logic [1:0]  pc_sel;
    logic [31:0] retired;
    logic [5:0]  obs;

    int   checks = 0;
    int   failures = 0;
    logic exp_fault = 1'b0;
    int   exp_retired = 0;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3;
    localparam int ST_MEM = 4, ST_WB = 5, ST_HALT = 6;

    stage_sequencer #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .func(func), .stop(stop),
        .alu_zero(alu_zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .FetchEnable(FetchEnable), .DecodeEnable(DecodeEnable), .ExecuteEnable(ExecuteEnable),
        .MemEnable(MemEnable), .WriteBackEnable(WriteBackEnable), .mem_read(mem_read),
        .mem_write(mem_write), .pc_write(pc_write), .pc_sel(pc_sel), .halted(halted),
        .fault(fault), .retired(retired)
    );

    assign obs = {FetchEnable, DecodeEnable, ExecuteEnable, MemEnable, WriteBackEnable, halted};

    always #5 clk = ~clk;

    function automatic logic [5:0] enables_for(input int st);
        case (st)
            ST_FETCH:  return 6'b100000;
            ST_DECODE: return 6'b010000;
            ST_EXEC:   return 6'b001000;
            ST_MEM:    return 6'b000100;
            ST_WB:     return 6'b000010;
            ST_HALT:   return 6'b000001;
            default:   return 6'b000000;
        endcase
    endfunction

    function automatic logic [31:0] model_retired(input int n);
`ifdef RETIRE_COUNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({obs, mem_read, mem_write, pc_write, pc_sel, fault} !== 12'd0 || retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: got obs=%b rd=%b wr=%b pcw=%b sel=%b fault=%b ret=%0d, want all 0",
                     obs, mem_read, mem_write, pc_write, pc_sel, fault, retired);
        end
        reset = 1'b0;
        exp_fault = 1'b0;
        exp_retired = 0;
    endtask

    task automatic do_start();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            start = (i == 1);
            imem_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== 6'b000000) begin
                failures++;
                $display("FAIL idle_wait: got obs=%b, want 000000", obs);
            end
        end
    endtask

    // Expected cycle trace built from the instruction's type: the list of stages it visits.
    task automatic run_instr(input logic [1:0] iop, input logic [4:0] ifunc, input logic istop,
                             input logic iaz, input int fwait, input int mwait, input int abort_at);
        int   q[$];
        bit   is_ld = 0, is_st = 0, wb = 0, ill = 0;
        logic [1:0] sel = 2'b00;
        int   mem_idx = 0;
        if (iop == 2'b00 || iop == 2'b11) begin
            if (ifunc <= 3) wb = 1; else ill = 1;
        end else if (iop == 2'b10) begin
            if (ifunc <= 1)       wb = 1;
            else if (ifunc == 2)  begin is_ld = 1; wb = 1; end
            else if (ifunc == 3)  is_st = 1;
            else if (ifunc == 4)  sel = iaz ? 2'b01 : 2'b00;
            else                  ill = 1;
        end else begin
            if (ifunc <= 1) sel = 2'b10; else ill = 1;
        end
        for (int i = 0; i <= fwait; i++) q.push_back(ST_FETCH);
        q.push_back(ST_DECODE);
        q.push_back(ST_EXEC);
        if (is_ld || is_st) for (int i = 0; i <= mwait; i++) q.push_back(ST_MEM);
        if (wb) q.push_back(ST_WB);

        for (int k = 0; k < q.size(); k++) begin
            @(posedge clk); #1;
            start = 1'($urandom);
            if (q[k] == ST_FETCH || q[k] == ST_DECODE) begin
                op = 2'($urandom); func = 5'($urandom); stop = 1'($urandom);
            end else begin
                op = iop; func = ifunc; stop = istop;
            end
            alu_zero   = (q[k] == ST_EXEC) ? iaz : 1'($urandom);
            imem_ready = (q[k] == ST_FETCH) ? (k == fwait) : 1'($urandom);
            dmem_ready = (q[k] == ST_MEM) ? (mem_idx == mwait) : 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== enables_for(q[k])) begin
                failures++;
                $display("FAIL stage op=%0d func=%0d cyc=%0d: got obs=%b, want %b", iop, ifunc, k, obs, enables_for(q[k]));
            end
            checks++;
            if (mem_read !== (q[k] == ST_MEM && is_ld) || mem_write !== (q[k] == ST_MEM && is_st)) begin
                failures++;
                $display("FAIL mem_strobe cyc=%0d: got rd=%b wr=%b, want rd=%b wr=%b", k, mem_read, mem_write,
                         (q[k] == ST_MEM && is_ld), (q[k] == ST_MEM && is_st));
            end
            checks++;
            if (pc_write !== (k == q.size() - 1)) begin
                failures++;
                $display("FAIL pc_write op=%0d func=%0d cyc=%0d: got %b, want %b", iop, ifunc, k, pc_write, (k == q.size() - 1));
            end
            if (k == q.size() - 1) begin
                checks++;
                if (pc_sel !== sel) begin
                    failures++;
                    $display("FAIL pc_sel op=%0d func=%0d az=%b: got %b, want %b", iop, ifunc, iaz, pc_sel, sel);
                end
            end
            checks++;
            if (fault !== exp_fault) begin
                failures++;
                $display("FAIL fault cyc=%0d: got %b, want %b", k, fault, exp_fault);
            end
            checks++;
            if (retired !== model_retired(exp_retired)) begin
                failures++;
                $display("FAIL retired cyc=%0d: got %0d, want %0d", k, retired, model_retired(exp_retired));
            end
            if (q[k] == ST_MEM) mem_idx++;
            if (q[k] == ST_EXEC && ill) exp_fault = 1'b1;
            if (k == abort_at) begin
                #2 reset = 1'b1;
                start = 1'b0;
                #1;
                checks++;
                if ({obs, mem_read, mem_write, pc_write, pc_sel, fault} !== 12'd0 || retired !== 32'd0) begin
                    failures++;
                    $display("FAIL async_reset: got obs=%b rd=%b wr=%b pcw=%b sel=%b fault=%b ret=%0d, want all 0",
                             obs, mem_read, mem_write, pc_write, pc_sel, fault, retired);
                end
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                exp_fault = 1'b0;
                exp_retired = 0;
                return;
            end
        end
        exp_retired++;
        if (istop) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                start = (i != 1);
                imem_ready = 1'($urandom);
                @(negedge clk);
                checks++;
                if (obs !== 6'b000001 || pc_write !== 1'b0) begin
                    failures++;
                    $display("FAIL halt_hold cyc=%0d: got obs=%b pcw=%b, want 000001 0", i, obs, pc_write);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_alu();
        do_reset(); do_start();
        run_instr(2'b00, 5'd1, 1'b0, 1'b0, 0, 0, -1);
        run_instr(2'b10, 5'd1, 1'b0, 1'b1, 2, 0, -1);
        run_instr(2'b11, 5'd3, 1'b0, 1'b0, 1, 0, -1);
        run_instr(2'b10, 5'd0, 1'b1, 1'b0, 0, 0, -1);
    endtask

    task automatic test_mem();
        do_reset(); do_start();
        run_instr(2'b10, 5'd2, 1'b0, 1'b0, 0, 3, -1);
        run_instr(2'b10, 5'd3, 1'b0, 1'b0, 0, 0, -1);
        run_instr(2'b10, 5'd2, 1'b0, 1'b0, 1, 0, -1);
        run_instr(2'b10, 5'd3, 1'b1, 1'b0, 3, 2, -1);
    endtask

    task automatic test_branch();
        do_reset(); do_start();
        run_instr(2'b10, 5'd4, 1'b0, 1'b1, 0, 0, -1);
        run_instr(2'b10, 5'd4, 1'b0, 1'b0, 0, 0, -1);
        run_instr(2'b01, 5'd0, 1'b0, 1'b0, 1, 0, -1);
        run_instr(2'b01, 5'd1, 1'b1, 1'b1, 0, 0, -1);
    endtask

    task automatic test_fault();
        do_reset(); do_start();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start = 1'b0; imem_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (obs !== 6'b100000 || fault !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait cyc=%0d: got obs=%b fault=%b, want 100000 0", i, obs, fault);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs !== 6'b000001 || fault !== 1'b1) begin
            failures++;
            $display("FAIL timeout_halt: got obs=%b fault=%b, want 000001 1", obs, fault);
        end
        do_reset(); do_start();
        run_instr(2'b10, 5'd7, 1'b0, 1'b0, 0, 0, -1);
        run_instr(2'b00, 5'd2, 1'b0, 1'b0, 0, 0, -1);
        run_instr(2'b01, 5'd5, 1'b0, 1'b0, 1, 0, -1);
        run_instr(2'b10, 5'd2, 1'b1, 1'b0, 0, 1, -1);
    endtask

    task automatic test_reset_mid_mem();
        do_reset(); do_start();
        run_instr(2'b10, 5'd2, 1'b0, 1'b0, 0, 3, 4);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 6'b000000 || retired !== 32'd0) begin
            failures++;
            $display("FAIL post_abort_idle: got obs=%b ret=%0d, want 000000 0", obs, retired);
        end
        do_start();
        run_instr(2'b00, 5'd0, 1'b1, 1'b0, 0, 0, -1);
    endtask

    task automatic test_retire_count();
        do_reset(); do_start();
        for (int i = 0; i < 10; i++) begin
            run_instr(2'b10, 5'($urandom_range(4, 0)), (i == 9), 1'($urandom),
                      $urandom_range(3, 0), $urandom_range(3, 0), -1);
        end
        checks++;
        if (retired !== model_retired(10)) begin
            failures++;
            $display("FAIL retired_ten: got %0d, want %0d", retired, model_retired(10));
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset(); do_start();
        for (int i = 0; i < 30; i++) begin
            run_instr(2'($urandom), 5'($urandom_range(7, 0)), (i == 29), 1'($urandom),
                      $urandom_range(3, 0), $urandom_range(3, 0), -1);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_fault();
        test_reset_mid_mem();
        test_retire_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multi-cycle control FSM for the five-stage non-pipelined RISC core: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
- Drives the per-stage enables, including DecodeEnable for the Decode stage, and sequences PC update and memory handshakes.
- Routes each instruction from its op/func fields through only the stages it needs, and halts after an instruction with the stop bit set.

Parameters:
- TIMEOUT, 255: max cycles to wait for imem_ready/dmem_ready before a fault; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; leaves IDLE.
- op  in  2  from Decode; 00 R, 01 J, 10 I, 11 S.
- func  in  5  from Decode.
- stop  in  1  from Decode; last-instruction bit.
- alu_zero  in  1  ALU zero flag; combinationally valid during EXECUTE.
- imem_ready  in  1  instruction word valid.
- dmem_ready  in  1  data access complete.
- FetchEnable  out  1  high in FETCH.
- DecodeEnable  out  1  high in DECODE.
- ExecuteEnable  out  1  high in EXECUTE.
- MemEnable  out  1  high in MEM.
- WriteBackEnable  out  1  high in WRITEBACK.
- mem_read  out  1  high in MEM for LW.
- mem_write  out  1  high in MEM for SW.
- pc_write  out  1  one-cycle pulse in an instruction's final state.
- pc_sel  out  2  00 PC+4, 01 branch (pcB), 10 jump (pcJ).
- halted  out  1  in HALT.
- fault  out  1  sticky; set on timeout or illegal func.
- retired  out  32  retired-instruction count (optional feature).

Behaviour:
- Reset (async, any state, including mid-MEM): state IDLE. All outputs 0, retired 0, wait counter 0.
- All outputs are Moore outputs decoded from state, except mem_read, mem_write, pc_sel and pc_write. Those are combinational from state plus op/func/alu_zero.
- Decode registers its fields at the end of DECODE, so op/func/stop are used only from EXECUTE onward.
- IDLE -> FETCH on start.
- FETCH:
  - Wait for imem_ready, then go to DECODE.
  - The wait counter increments each cycle without ready.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT, set fault and go to HALT.
  - The counter clears on every state change.
- DECODE -> EXECUTE, always one cycle.
- EXECUTE routing:
  - R or S type (func 0-3): go to WRITEBACK.
  - I type, ANDI(0) or ADDI(1): go to WRITEBACK.
  - I type, LW(2) or SW(3): go to MEM.
  - I type, BEQ(4): final state. pc_sel=01 if alu_zero else 00. pc_write=1.
  - J type, J(0) or JAL(1): final state. pc_sel=10, pc_write=1.
  - Any undefined func: set fault, treat as NOP (final state, pc_sel=00, pc_write=1).
- MEM:
  - Hold mem_read (LW) or mem_write (SW) until dmem_ready. The same timeout rule as FETCH applies.
  - On ready: LW goes to WRITEBACK. SW is final (pc_sel=00, pc_write=1).
- WRITEBACK: final state, one cycle, pc_sel=00, pc_write=1.
- Exit from a final state: go to HALT if stop=1, otherwise FETCH.
- HALT: absorbing state. halted=1, all enables 0. Left only by reset; start is ignored.
- A start pulse outside IDLE is ignored.
- Exactly one stage enable is high in any non-IDLE/HALT state.
- Per-instruction latency: BEQ/J/SW-fast 3-4 cycles, ALU 4, LW 5, plus memory waits.

Optional Feature:
- Macro: RETIRE_COUNT_EN.
- Defined: retired increments by 1 on each pc_write pulse and wraps at 2^32-1 -> 0. Reset clears it.
- Undefined: no counter is instantiated and retired is tied to 0.

Decomposition:
- Package sequencer_pkg holds:
  - state encoding: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT (3 bits).
  - op codes: OP_R, OP_J, OP_I, OP_S.
  - func codes: ANDI, ADDI, LW, SW, BEQ, J, JAL, and R/S func max value 3.
  - pc_sel encodings: PC_INC, PC_BR, PC_JMP.
- One sub-module, wait_timer: the wait counter plus timeout compare, reused for FETCH and MEM.

Test Plan:
- Reset, start, ADD (op=00 func=1 stop=0) with imem_ready held high -> FETCH, DECODE, EXECUTE, WRITEBACK on cycles 1-4. pc_write on cycle 4 with pc_sel=00. Back in FETCH on cycle 5.
- LW with dmem_ready delayed 3 cycles -> MEM held 4 cycles with mem_read=1, then WRITEBACK. SW -> final in MEM with mem_write=1, no WRITEBACK.
- BEQ with alu_zero=1 -> pc_sel=01. With alu_zero=0 -> pc_sel=00. J -> pc_sel=10. All three retire in EXECUTE.
- Instruction with stop=1 -> halted=1 the cycle after its pc_write. Further start pulses are ignored.
- TIMEOUT=4 with imem_ready stuck low -> fault=1 and HALT after 4 FETCH cycles. Illegal I func 7 -> fault=1 while execution continues.
- Assert reset during MEM -> immediately IDLE, all outputs 0. With RETIRE_COUNT_EN, retired counts 10 after 10 instructions, then clears on reset.
